seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial bit-pattern detector. It is the successor to the fixed
//  4-bit "0110" detector FSM.
//  Features: PAT_W-bit pattern loadable at run time, overlap/non-overlap mode,
//  input-valid qualifier, registered detect pulse, saturating match counter.
//  Sits between a serial bit source and the status/interrupt logic.
// PARAMETERS
//  PAT_W    4        pattern length in bits (2..32)
//  PAT_INIT 4'b0110  active pattern after reset; MSB = first bit received
//  CNT_W    8        width of match counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rstn         in   1      reset: asynchronous, active-high (rstn=1 resets)
//  din_valid    in   1      din_bit is sampled only when 1
//  din_bit      in   1      serial data bit
//  cfg_load     in   1      1-cycle strobe: latch cfg_pattern/cfg_overlap
//  cfg_pattern  in   PAT_W  new pattern (MSB first)
//  cfg_overlap  in   1      1 = overlapping matches, 0 = non-overlapping
//  detect_out   out  1      1-cycle pulse per match
//  det_count    out  CNT_W  number of matches since reset/clear
//  count_sat    out  1      1 while det_count is at all-ones
//  cnt_clr      in   1      synchronous clear of det_count/count_sat
// BEHAVIOUR
//  Reset (rstn=1, async):
//  - pattern_q=PAT_INIT, overlap_q=1, hist=0, fill=0.
//  - detect_out=0, det_count=0, count_sat=0.
//  - Outputs are held while rstn=1. Operation resumes on the first clk edge
//    after rstn falls.
//  Internal state:
//  - hist[PAT_W-1:0] holds the last valid bits, newest in bit 0.
//  - fill (0..PAT_W) counts valid bits held and saturates at PAT_W.
//  Per rising edge, in priority order:
//  1 cfg_load=1:
//    - pattern_q<=cfg_pattern, overlap_q<=cfg_overlap, hist<=0, fill<=0.
//    - din_valid in the same cycle is ignored. detect_out<=0.
//  2 else if din_valid=1:
//    - nxt = {hist[PAT_W-2:0], din_bit}.
//    - match = (fill >= PAT_W-1) && (nxt == pattern_q).
//    - hist<=nxt.
//    - On match with overlap_q=0: fill<=0 (the next match needs PAT_W fresh
//      bits).
//    - Otherwise fill<=min(fill+1, PAT_W).
//    - detect_out<=match.
//  3 else (din_valid=0): hist and fill hold; detect_out<=0.
//  Latency:
//  - detect_out goes high on the clk edge that samples the last pattern bit.
//    It is visible for the following cycle (registered, 1-cycle latency).
//  - There is no combinational path from inputs to outputs.
//  Counter:
//  - On a registered match: det_count<=det_count+1 unless all-ones, in which
//    case it holds.
//  - count_sat = (det_count == all-ones), registered with det_count.
//  - cnt_clr=1 zeros det_count and count_sat on the next edge. cnt_clr wins
//    over a simultaneous match: the count becomes 0 and that match is
//    dropped, but detect_out still pulses.
//  - cfg_load does not clear the counter.
//  Boundaries:
//  - Gaps in din_valid do not break a partial match.
//  - The first match cannot occur before PAT_W valid bits have been received
//    since reset/cfg_load, even when the pattern is all zeros.
//  - Reset in the middle of a pattern discards the partial match.
// TESTING
//  T1 defaults, overlap: valid bits 0,1,1,0,1,1,0 -> detect_out pulses after
//     bit4 and bit7; det_count=2.
//  T2 cfg_load pattern=0110 overlap=0, same 7 bits -> single pulse after bit4;
//     det_count=1.
//  T3 0,1 then din_valid low 3 cycles, then 1,0 -> one pulse after the final
//     0; no pulse during the gap.
//  T4 CNT_W=2, 5 separate matches -> det_count 1,2,3,3,3; count_sat=1 from the
//     3rd match. Then cnt_clr together with a match -> det_count=0,
//     detect_out=1.
//  T5 bits 0,1,1, rstn pulse 1 cycle, then 0 -> no detect. Outputs read 0
//     during reset. Then 0,1,1,0 -> detect.
//  T6 cfg_load pattern=0000 on the same cycle as din_valid=1 -> that bit is
//     dropped. Four 0s -> pulse after the 4th; a 5th 0 (overlap=1) -> pulse.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial input, configuration strobe,
// counter clear, detect/count outputs and debug state taps.
interface seq_detector_param_if #(
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int FILL_W = $clog2(PAT_W + 1)
);
  // Handshake: din_bit is qualified by din_valid. There is no backpressure,
  // so every cycle with din_valid=1 consumes one bit. cfg_load and cnt_clr
  // are single-cycle strobes.
  logic             din_valid;
  logic             din_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             cnt_clr;

  logic             detect_out;
  logic [CNT_W-1:0] det_count;
  logic             count_sat;

  logic [FILL_W-1:0] dbg_fill;
  logic [PAT_W-1:0]  dbg_hist;
  logic [PAT_W-1:0]  dbg_pattern;
  logic              dbg_overlap;

  modport master (
    output din_valid, din_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    input  detect_out, det_count, count_sat,
    input  dbg_fill, dbg_hist, dbg_pattern, dbg_overlap
  );

  modport slave (
    input  din_valid, din_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    output detect_out, det_count, count_sat,
    output dbg_fill, dbg_hist, dbg_pattern, dbg_overlap
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a run-time loadable pattern, overlap or
// non-overlap matching, a registered detect pulse and a saturating counter.
module seq_detector_param #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b0110),
  parameter int               CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  seq_detector_param_if.slave  bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              overlap_q, overlap_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              detect_q, detect_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sat_q, sat_d;

  logic [PAT_W-1:0]  nxt;
  logic              match;

  // State register. Reset is active-high despite the port name.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pattern_q <= PAT_INIT;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      detect_q  <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      detect_q  <= detect_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  // Next-state: configuration load takes priority over a valid data bit.
  always_comb begin
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    detect_d  = 1'b0;
    match     = 1'b0;
    nxt       = {hist_q[PAT_W-2:0], bus.din_bit};

    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      overlap_d = bus.cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (bus.din_valid) begin
      // fill gate stops an all-zero pattern matching the cleared history
      match  = (fill_q >= FILL_LAST) && (nxt == pattern_q);
      hist_d = nxt;
      if (match && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
      detect_d = match;
    end
  end

  // Counter: clear beats a coincident match; the pulse itself is unaffected.
  always_comb begin
    count_d = count_q;
    if (bus.cnt_clr) begin
      count_d = '0;
    end else if (match && !sat_q) begin
      count_d = count_q + CNT_W'(1);
    end
    sat_d = &count_d;
  end

  // Outputs come straight from flops.
  assign bus.detect_out  = detect_q;
  assign bus.det_count   = count_q;
  assign bus.count_sat   = sat_q;
  assign bus.dbg_fill    = fill_q;
  assign bus.dbg_hist    = hist_q;
  assign bus.dbg_pattern = pattern_q;
  assign bus.dbg_overlap = overlap_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: an 8-bit and a 2-bit counter
// instance receive identical stimulus and are checked against hand values.
module tb_seq_detector_param;
  logic clk;
  logic rstn;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus8 ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b0110), .CNT_W(8)) dut8 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus8)
  );

  seq_detector_param #(.PAT_W(4), .PAT_INIT(4'b0110), .CNT_W(2)) dut2 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus2)
  );

  typedef struct {
    logic       v;
    logic       b;
    logic       ld;
    logic [3:0] pat;
    logic       ovl;
    logic       clr;
    logic       e_det;
    logic [7:0] e_c8;
    logic [1:0] e_c2;
    logic       e_s2;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic b, logic ld, logic [3:0] pat,
                              logic ovl, logic clr, logic e_det,
                              logic [7:0] e_c8, logic [1:0] e_c2, logic e_s2);
    vec_t r;
    r.v = v; r.b = b; r.ld = ld; r.pat = pat; r.ovl = ovl; r.clr = clr;
    r.e_det = e_det; r.e_c8 = e_c8; r.e_c2 = e_c2; r.e_s2 = e_s2;
    return r;
  endfunction

  task automatic drive(input logic v, input logic b, input logic ld,
                       input logic [3:0] pat, input logic ovl, input logic clr);
    bus8.din_valid = v;   bus2.din_valid = v;
    bus8.din_bit = b;     bus2.din_bit = b;
    bus8.cfg_load = ld;   bus2.cfg_load = ld;
    bus8.cfg_pattern = pat; bus2.cfg_pattern = pat;
    bus8.cfg_overlap = ovl; bus2.cfg_overlap = ovl;
    bus8.cnt_clr = clr;   bus2.cnt_clr = clr;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compares both instances against the oldest queued expectation.
  task automatic check_outputs(input string tag);
    logic [11:0] e;
    logic        e_det, e_s2;
    logic [7:0]  e_c8;
    logic [1:0]  e_c2;
    e = exp_q.pop_front();
    {e_det, e_c8, e_c2, e_s2} = e;
    chk({tag, " det8"}, 8'(bus8.detect_out), 8'(e_det));
    chk({tag, " det2"}, 8'(bus2.detect_out), 8'(e_det));
    chk({tag, " cnt8"}, bus8.det_count, e_c8);
    chk({tag, " sat8"}, 8'(bus8.count_sat), 8'(e_c8 == 8'hff));
    chk({tag, " cnt2"}, 8'(bus2.det_count), 8'(e_c2));
    chk({tag, " sat2"}, 8'(bus2.count_sat), 8'(e_s2));
  endtask

  task automatic step(input vec_t t, input string tag);
    drive(t.v, t.b, t.ld, t.pat, t.ovl, t.clr);
    exp_q.push_back({t.e_det, t.e_c8, t.e_c2, t.e_s2});
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic bit_in(input logic b, input logic e_det, input logic [7:0] e_c8,
                        input logic [1:0] e_c2, input logic e_s2, input string tag);
    step(mk(1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0, e_det, e_c8, e_c2, e_s2), tag);
  endtask

  initial begin
    rstn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(12'h000);
    check_outputs("reset");
    rstn = 1'b0;

    // T1: default pattern 0110, overlapping
    tbl.push_back(mk(1,0,0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 1,1,1,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,1,1,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,1,1,0));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 1,2,2,0));
    // T2: non-overlap, same bits -> one match; count not cleared by load
    tbl.push_back(mk(0,0,1,4'b0110,0,0, 0,2,2,0));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 0,2,2,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,2,2,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,2,2,0));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 1,3,3,1));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,3,3,1));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,3,3,1));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 0,3,3,1));
    tbl.push_back(mk(0,0,0,4'h0,0,1, 0,0,0,0));
    // T3: gap in din_valid keeps the partial match
    tbl.push_back(mk(0,0,1,4'b0110,1,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,0,0,0));
    for (int g = 0; g < 3; g++) tbl.push_back(mk(0,1,0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,0,0, 1,1,1,0));
    // T4: saturation of the 2-bit counter, then clear against a match
    tbl.push_back(mk(0,0,0,4'h0,0,1, 0,0,0,0));
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] p2, c2;
      p2 = (k - 1 >= 3) ? 2'd3 : 2'(k - 1);
      c2 = (k >= 3) ? 2'd3 : 2'(k);
      tbl.push_back(mk(1,0,0,4'h0,0,0, 0,8'(k-1),p2,(k-1) >= 3));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 0,8'(k-1),p2,(k-1) >= 3));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 0,8'(k-1),p2,(k-1) >= 3));
      tbl.push_back(mk(1,0,0,4'h0,0,0, 1,8'(k),c2,k >= 3));
    end
    tbl.push_back(mk(1,0,0,4'h0,0,0, 0,5,3,1));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,5,3,1));
    tbl.push_back(mk(1,1,0,4'h0,0,0, 0,5,3,1));
    tbl.push_back(mk(1,0,0,4'h0,0,1, 1,0,0,0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // T5: reset in the middle of a partial pattern
    bit_in(1'b0, 1'b0, 8'd0, 2'd0, 1'b0, "t5a");
    bit_in(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, "t5b");
    bit_in(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, "t5c");
    bit_in(1'b0, 1'b1, 8'd1, 2'd1, 1'b0, "t5d");
    bit_in(1'b0, 1'b0, 8'd1, 2'd1, 1'b0, "t5e");
    bit_in(1'b1, 1'b0, 8'd1, 2'd1, 1'b0, "t5f");
    bit_in(1'b1, 1'b0, 8'd1, 2'd1, 1'b0, "t5g");
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    exp_q.push_back(12'h000);
    check_outputs("t5 async rst");
    @(posedge clk);
    #1;
    exp_q.push_back(12'h000);
    check_outputs("t5 held rst");
    rstn = 1'b0;
    bit_in(1'b0, 1'b0, 8'd0, 2'd0, 1'b0, "t5 after rst");
    bit_in(1'b0, 1'b0, 8'd0, 2'd0, 1'b0, "t5h");
    bit_in(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, "t5i");
    bit_in(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, "t5j");
    bit_in(1'b0, 1'b1, 8'd1, 2'd1, 1'b0, "t5k");

    // T6: all-zero pattern, load drops the coincident bit
    step(mk(1,0,1,4'b0000,1,0, 0,1,1,0), "t6 load");
    bit_in(1'b0, 1'b0, 8'd1, 2'd1, 1'b0, "t6 z1");
    bit_in(1'b0, 1'b0, 8'd1, 2'd1, 1'b0, "t6 z2");
    bit_in(1'b0, 1'b0, 8'd1, 2'd1, 1'b0, "t6 z3");
    bit_in(1'b0, 1'b1, 8'd2, 2'd2, 1'b0, "t6 z4");
    bit_in(1'b0, 1'b1, 8'd3, 2'd3, 1'b1, "t6 z5");
    bit_in(1'b1, 1'b0, 8'd3, 2'd3, 1'b1, "t6 one");
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
